// File: rtl/handshake_rx_pkg.sv
// Shared types and constants for the four-phase handshake receiver.
package handshake_rx_pkg;

  typedef enum logic {ST_IDLE, ST_ACK} hs_rx_state_e;

  localparam int SYNC_STAGES_MIN = 2;

endpackage

// File: rtl/sync_bit.sv
// N-stage single-bit synchronizer, synchronous active-high reset.
module sync_bit #(
  parameter int unsigned N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [N-1:0] stages_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stages_q <= '0;
    end else begin
      stages_q <= {stages_q[N-2:0], d_i};
    end
  end

  assign q_o = stages_q[N-1];

endmodule

// File: rtl/handshake_rx.sv
// Receive end of a four-phase req/ack handshake feeding a valid/ready stream.
// Optional even-parity check is enabled by defining HANDSHAKE_RX_PARITY_EN.
module handshake_rx
  import handshake_rx_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ack_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  input  logic              ready_i,
`ifdef HANDSHAKE_RX_PARITY_EN
  input  logic              par_i,
  output logic              par_err_o,
`endif
  output logic [CNT_W-1:0]  xfer_cnt_o
);

  // A one-stage synchronizer is never safe; fall back to the minimum depth.
  localparam int unsigned SyncN = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : SYNC_STAGES;

  hs_rx_state_e      state_q, state_d;
  logic              req_s;
  logic              free;
  logic              capture;
  logic              accept;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  sync_bit #(
    .N (SyncN)
  ) u_req_sync (
    .clk (clk),
    .rst (rst),
    .d_i (req_i),
    .q_o (req_s)
  );

  assign accept = valid_q && ready_i;
  assign free   = !valid_q || ready_i;

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // With the buffer full, ack is withheld so the sender stalls holding its data.
        if (req_s && free) begin
          capture = 1'b1;
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        if (!req_s) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    if (accept) begin
      valid_d = 1'b0;
      cnt_d   = cnt_q + CNT_W'(1);
    end
    if (capture) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HANDSHAKE_RX_PARITY_EN
  logic par_err_q, par_err_d;

  always_comb begin
    par_err_d = par_err_q;
    if (capture) begin
      par_err_d = ((^data_i) != par_i);
    end else if (accept) begin
      par_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      par_err_q <= 1'b0;
    end else begin
      par_err_q <= par_err_d;
    end
  end

  assign par_err_o = par_err_q;
`endif

  assign ack_o      = (state_q == ST_ACK);
  assign valid_o    = valid_q;
  assign data_o     = data_q;
  assign xfer_cnt_o = cnt_q;

endmodule

// File: tb/tb_handshake_rx.sv
// Directed self-checking bench for handshake_rx (SYNC_STAGES=2 and a SYNC_STAGES=3 copy).
module tb_handshake_rx;

  localparam int DW = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_i, ready_i, ack_o, valid_o;
  logic [DW-1:0] data_i, data_o;
  logic [CW-1:0] xfer_cnt_o;
  logic          req3, ready3, ack3, valid3;
  logic [DW-1:0] data3_i, data3_o;
  logic [CW-1:0] cnt3;
`ifdef HANDSHAKE_RX_PARITY_EN
  logic          par_i, par_err_o, par3_i, par3_err;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  handshake_rx #(.DATA_W(DW), .SYNC_STAGES(2), .CNT_W(CW)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req_i),
    .data_i     (data_i),
    .ack_o      (ack_o),
    .valid_o    (valid_o),
    .data_o     (data_o),
    .ready_i    (ready_i),
`ifdef HANDSHAKE_RX_PARITY_EN
    .par_i      (par_i),
    .par_err_o  (par_err_o),
`endif
    .xfer_cnt_o (xfer_cnt_o)
  );

  handshake_rx #(.DATA_W(DW), .SYNC_STAGES(3), .CNT_W(CW)) u_dut3 (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req3),
    .data_i     (data3_i),
    .ack_o      (ack3),
    .valid_o    (valid3),
    .data_o     (data3_o),
    .ready_i    (ready3),
`ifdef HANDSHAKE_RX_PARITY_EN
    .par_i      (par3_i),
    .par_err_o  (par3_err),
`endif
    .xfer_cnt_o (cnt3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input logic level, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (ack_o === level) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++;
    if (ack_o !== 1'b0 || valid_o !== 1'b0 || data_o !== 8'h00 || xfer_cnt_o !== 16'd0)
      $display("FAIL reset: ack=%b valid=%b data=%h cnt=%0d required 0/0/00/0",
               ack_o, valid_o, data_o, xfer_cnt_o);
    else n_pass++;
    n_checks++;
    if (ack3 !== 1'b0 || valid3 !== 1'b0 || data3_o !== 8'h00 || cnt3 !== 16'd0)
      $display("FAIL reset_s3: ack=%b valid=%b data=%h cnt=%0d required 0/0/00/0",
               ack3, valid3, data3_o, cnt3);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_single();
    ready_i = 1'b1;
    data_i  = 8'hA5;
    req_i   = 1'b1;
    tick();  // E
    tick();  // E+1
    n_checks++;
    if (ack_o !== 1'b0 || valid_o !== 1'b0)
      $display("FAIL single_early: ack=%b valid=%b required 0/0", ack_o, valid_o);
    else n_pass++;
    tick();  // E+2
    n_checks++;
    if (ack_o !== 1'b1 || valid_o !== 1'b1 || data_o !== 8'hA5)
      $display("FAIL single_capture: ack=%b valid=%b data=%h required 1/1/a5",
               ack_o, valid_o, data_o);
    else n_pass++;
    tick();
    n_checks++;
    if (valid_o !== 1'b0 || xfer_cnt_o !== 16'd1)
      $display("FAIL single_accept: valid=%b cnt=%0d required 0/1", valid_o, xfer_cnt_o);
    else n_pass++;
    req_i = 1'b0;
    tick();  // F
    tick();  // F+1
    n_checks++;
    if (ack_o !== 1'b1) $display("FAIL single_ack_hold: ack=%b required 1", ack_o);
    else n_pass++;
    tick();  // F+2
    n_checks++;
    if (ack_o !== 1'b0) $display("FAIL single_ack_fall: ack=%b required 0", ack_o);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    bit ok;
    int bad = 0;
    ready_i = 1'b0;
    data_i  = 8'h11;
    req_i   = 1'b1;
    wait_ack(1'b1, 20, ok);
    n_checks++;
    if (!ok || valid_o !== 1'b1 || data_o !== 8'h11)
      $display("FAIL bp_first: ack_seen=%b valid=%b data=%h required 1/1/11", ok, valid_o, data_o);
    else n_pass++;
    req_i = 1'b0;
    wait_ack(1'b0, 20, ok);
    data_i = 8'h22;
    req_i  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (ack_o !== 1'b0 || valid_o !== 1'b1 || data_o !== 8'h11) bad++;
    end
    n_checks++;
    if (!ok || bad != 0)
      $display("FAIL bp_stall: ack_fell=%b bad_cycles=%0d required 1/0", ok, bad);
    else n_pass++;
    ready_i = 1'b1;
    tick();
    n_checks++;
    if (valid_o !== 1'b1 || data_o !== 8'h22 || ack_o !== 1'b1 || xfer_cnt_o !== 16'd2)
      $display("FAIL bp_swap: valid=%b data=%h ack=%b cnt=%0d required 1/22/1/2",
               valid_o, data_o, ack_o, xfer_cnt_o);
    else n_pass++;
    tick();
    n_checks++;
    if (valid_o !== 1'b0 || xfer_cnt_o !== 16'd3)
      $display("FAIL bp_drain: valid=%b cnt=%0d required 0/3", valid_o, xfer_cnt_o);
    else n_pass++;
    req_i = 1'b0;
    wait_ack(1'b0, 20, ok);
  endtask

  task automatic test_back_to_back();
    int got = 0;
    int bad = 0;
    int timeouts = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    fork
      begin
        bit ok;
        for (int w = 0; w < 256; w++) begin
          data_i = 8'(w);
          req_i  = 1'b1;
          wait_ack(1'b1, 200, ok);
          if (!ok) timeouts++;
          req_i = 1'b0;
          wait_ack(1'b0, 200, ok);
          if (!ok) timeouts++;
        end
      end
      begin
        int cyc = 0;
        while (got < 256 && cyc < 40000) begin
          @(negedge clk);
          cyc++;
          ready_i = 1'($urandom_range(0, 1));
          if (valid_o && ready_i) begin
            if (data_o !== 8'(got)) bad++;
            got++;
          end
        end
        tick();
        n_checks++;
        if (xfer_cnt_o !== 16'd256)
          $display("FAIL stream_cnt: cnt=%0d required 256", xfer_cnt_o);
        else n_pass++;
      end
    join
    ready_i = 1'b1;
    n_checks++;
    if (got != 256 || bad != 0 || timeouts != 0)
      $display("FAIL stream_order: words=%0d out_of_order=%0d timeouts=%0d required 256/0/0",
               got, bad, timeouts);
    else n_pass++;
    tick();
    n_checks++;
    if (valid_o !== 1'b0 || xfer_cnt_o !== 16'd256)
      $display("FAIL stream_no_dup: valid=%b cnt=%0d required 0/256", valid_o, xfer_cnt_o);
    else n_pass++;
  endtask

  task automatic test_reset_in_ack();
    bit ok;
    ready_i = 1'b0;
    data_i  = 8'h5A;
    req_i   = 1'b1;
    wait_ack(1'b1, 20, ok);
    rst = 1'b1;
    tick();  // R
    rst = 1'b0;
    n_checks++;
    if (!ok || ack_o !== 1'b0 || valid_o !== 1'b0 || data_o !== 8'h00 || xfer_cnt_o !== 16'd0)
      $display("FAIL rst_ack_clear: ack_seen=%b ack=%b valid=%b data=%h cnt=%0d required 1/0/0/00/0",
               ok, ack_o, valid_o, data_o, xfer_cnt_o);
    else n_pass++;
    tick();  // R+1
    tick();  // R+2
    n_checks++;
    if (ack_o !== 1'b0 || valid_o !== 1'b0)
      $display("FAIL rst_ack_early: ack=%b valid=%b required 0/0", ack_o, valid_o);
    else n_pass++;
    tick();  // R+3
    n_checks++;
    if (ack_o !== 1'b1 || valid_o !== 1'b1 || data_o !== 8'h5A)
      $display("FAIL rst_ack_recapture: ack=%b valid=%b data=%h required 1/1/5a",
               ack_o, valid_o, data_o);
    else n_pass++;
    ready_i = 1'b1;
    tick();
    n_checks++;
    if (valid_o !== 1'b0 || xfer_cnt_o !== 16'd1)
      $display("FAIL rst_ack_accept: valid=%b cnt=%0d required 0/1", valid_o, xfer_cnt_o);
    else n_pass++;
    req_i = 1'b0;
    wait_ack(1'b0, 20, ok);
  endtask

`ifdef HANDSHAKE_RX_PARITY_EN
  task automatic test_parity();
    bit ok;
    ready_i = 1'b0;
    data_i  = 8'h03;
    par_i   = 1'b0;
    req_i   = 1'b1;
    wait_ack(1'b1, 20, ok);
    n_checks++;
    if (!ok || par_err_o !== 1'b0 || data_o !== 8'h03)
      $display("FAIL par_good: ack_seen=%b err=%b data=%h required 1/0/03", ok, par_err_o, data_o);
    else n_pass++;
    req_i = 1'b0;
    wait_ack(1'b0, 20, ok);
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    data_i  = 8'h07;
    req_i   = 1'b1;
    wait_ack(1'b1, 20, ok);
    n_checks++;
    if (!ok || par_err_o !== 1'b1 || data_o !== 8'h07 || valid_o !== 1'b1)
      $display("FAIL par_bad: ack_seen=%b err=%b data=%h valid=%b required 1/1/07/1",
               ok, par_err_o, data_o, valid_o);
    else n_pass++;
    ready_i = 1'b1;
    tick();
    n_checks++;
    if (par_err_o !== 1'b0 || valid_o !== 1'b0)
      $display("FAIL par_clear: err=%b valid=%b required 0/0", par_err_o, valid_o);
    else n_pass++;
    req_i = 1'b0;
    wait_ack(1'b0, 20, ok);
  endtask
`endif

  task automatic test_sync3();
    data3_i = 8'h3C;
    req3    = 1'b1;
    tick();  // E
    tick();  // E+1
    tick();  // E+2
    n_checks++;
    if (ack3 !== 1'b0 || valid3 !== 1'b0)
      $display("FAIL s3_early: ack=%b valid=%b required 0/0", ack3, valid3);
    else n_pass++;
    tick();  // E+3
    n_checks++;
    if (ack3 !== 1'b1 || valid3 !== 1'b1 || data3_o !== 8'h3C)
      $display("FAIL s3_capture: ack=%b valid=%b data=%h required 1/1/3c", ack3, valid3, data3_o);
    else n_pass++;
    req3 = 1'b0;
    tick();  // F
    tick();  // F+1
    tick();  // F+2
    n_checks++;
    if (ack3 !== 1'b1) $display("FAIL s3_ack_hold: ack=%b required 1", ack3);
    else n_pass++;
    tick();  // F+3
    n_checks++;
    if (ack3 !== 1'b0 || cnt3 !== 16'd1)
      $display("FAIL s3_ack_fall: ack=%b cnt=%0d required 0/1", ack3, cnt3);
    else n_pass++;
  endtask

  initial begin
    rst     = 1'b1;
    req_i   = 1'b0;
    data_i  = '0;
    ready_i = 1'b0;
    req3    = 1'b0;
    data3_i = '0;
    ready3  = 1'b1;
`ifdef HANDSHAKE_RX_PARITY_EN
    par_i  = 1'b0;
    par3_i = 1'b0;
`endif
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_reset_in_ack();
`ifdef HANDSHAKE_RX_PARITY_EN
    test_parity();
`endif
    test_sync3();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
